// File: rtl/countdown_timer_if.sv
// Control/status bundle between the board switch/key logic and countdown_timer.
// The hex display path consumes q, tick, busy and done from the same bundle.
interface countdown_timer_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 26
);
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic                 start;
  logic                 enable;
  logic                 auto_reload;
  logic [DIV_WIDTH-1:0] div_max;
  logic [WIDTH-1:0]     q;
  logic                 tick;
  logic                 busy;
  logic                 done;

  modport master (
    output load, load_value, start, enable, auto_reload, div_max,
    input  q, tick, busy, done
  );

  modport slave (
    input  load, load_value, start, enable, auto_reload, div_max,
    output q, tick, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with start/done handshake and optional auto-reload.
// q[7:4] and q[3:0] drive the seven-segment decoders; all outputs come from flops.
module countdown_timer #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     q_reg, q_next;
  logic [WIDTH-1:0]     reload_reg, reload_next;
  logic [DIV_WIDTH-1:0] presc, presc_next;
  logic                 tick_reg, tick_next;
  logic                 done_reg, done_next;
  logic                 presc_hit;
  logic                 terminal;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
      presc      <= '0;
      tick_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      q_reg      <= q_next;
      reload_reg <= reload_next;
      presc      <= presc_next;
      tick_reg   <= tick_next;
      done_reg   <= done_next;
    end
  end

  // >= rather than == so lowering div_max below the running prescaler ticks at once.
  assign presc_hit = (presc >= bus.div_max);
  // Treating q==0 as terminal too guarantees q can never wrap below zero.
  assign terminal  = (q_reg <= WIDTH'(1));

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    q_next      = q_reg;
    reload_next = reload_reg;
    presc_next  = presc;
    tick_next   = 1'b0;
    done_next   = 1'b0;

    if (bus.load) begin
      q_next      = bus.load_value;
      reload_next = bus.load_value;
      presc_next  = '0;
      state_next  = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            presc_next = '0;
            if (q_reg != '0) begin
              state_next = S_RUN;
            end else begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end
          end
        end

        S_DONE: begin
          if (bus.start) begin
            q_next     = reload_reg;
            presc_next = '0;
            if (reload_reg != '0) state_next = S_RUN;
            else                  done_next  = 1'b1;
          end
        end

        S_RUN: begin
          if (bus.enable) begin
            if (presc_hit) begin
              presc_next = '0;
              tick_next  = 1'b1;
              if (terminal) begin
                done_next = 1'b1;
                if (bus.auto_reload) begin
                  q_next = reload_reg;
                end else begin
                  q_next     = '0;
                  state_next = S_DONE;
                end
              end else begin
                q_next = q_reg - WIDTH'(1);
              end
            end else begin
              presc_next = presc + DIV_WIDTH'(1);
            end
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.q    = q_reg;
    bus.tick = tick_reg;
    bus.done = done_reg;
    bus.busy = (state == S_RUN);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a cycle-level reference model checked every
// negedge, plus hand-computed literal checkpoints through each scenario.
module tb_countdown_timer;

  localparam int WIDTH     = 8;
  localparam int DIV_WIDTH = 26;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   cmp_en      = 1'b0;

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: spec rules stated directly (elapsed enabled cycles vs div_max).
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t      m_mode;
  logic [7:0] m_q, m_rel;
  int         m_elapsed;
  logic       m_tick, m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode    <= M_IDLE;
      m_q       <= '0;
      m_rel     <= '0;
      m_elapsed <= 0;
      m_tick    <= 1'b0;
      m_done    <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      m_done <= 1'b0;
      if (bus.load) begin
        m_q       <= bus.load_value;
        m_rel     <= bus.load_value;
        m_elapsed <= 0;
        m_mode    <= M_IDLE;
      end else if (bus.start && m_mode != M_RUN) begin
        if (m_mode == M_DONE) m_q <= m_rel;
        m_elapsed <= 0;
        if (((m_mode == M_DONE) ? m_rel : m_q) == 8'd0) begin
          m_mode <= M_DONE;
          m_done <= 1'b1;
        end else begin
          m_mode <= M_RUN;
        end
      end else if (m_mode == M_RUN && bus.enable) begin
        if (m_elapsed >= int'(bus.div_max)) begin
          m_elapsed <= 0;
          m_tick    <= 1'b1;
          if (m_q == 8'd1) begin
            m_done <= 1'b1;
            if (bus.auto_reload) m_q <= m_rel;
            else begin
              m_q    <= 8'd0;
              m_mode <= M_DONE;
            end
          end else begin
            m_q <= m_q - 8'd1;
          end
        end else begin
          m_elapsed <= m_elapsed + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_q",    bus.q,    m_q);
      check("cyc_tick", bus.tick, m_tick);
      check("cyc_done", bus.done, m_done);
      check("cyc_busy", bus.busy, (m_mode == M_RUN));
    end
  end

  // Inputs change 2 time units after each rising edge, well clear of sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_pulse(input logic [7:0] v);
    bus.load_value = v;
    bus.load       = 1'b1;
    step(1);
    bus.load       = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      step(1);
      n++;
    end
    check(name, bus.done, 1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.load_value  = '0;
    bus.start       = 1'b0;
    bus.enable      = 1'b0;
    bus.auto_reload = 1'b0;
    bus.div_max     = '0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    step(2);
    reset = 1'b1;

    // Reset mid-run, then load basics
    load_pulse(8'h37);
    bus.div_max = 20;
    bus.enable  = 1'b1;
    start_pulse();
    step(2);
    check("t1_busy_run", bus.busy, 1);
    check("t1_q_run",    bus.q,    8'h37);
    reset = 1'b0;
    #1;
    check("t1_rst_q",    bus.q,    0);
    check("t1_rst_busy", bus.busy, 0);
    check("t1_rst_tick", bus.tick, 0);
    check("t1_rst_done", bus.done, 0);
    step(1);
    reset = 1'b1;
    load_pulse(8'h05);
    check("t1_load_q",    bus.q,    8'h05);
    check("t1_load_busy", bus.busy, 0);

    // Basic countdown: 3 -> 0 with div_max=2
    load_pulse(8'd3);
    bus.div_max = 2;
    start_pulse();
    check("t2_busy_rise", bus.busy, 1);
    check("t2_q_start",   bus.q,    3);
    step(2);
    check("t2_q_wait",    bus.q,    3);
    check("t2_tick_wait", bus.tick, 0);
    step(1);
    check("t2_q2",    bus.q,    2);
    check("t2_tick2", bus.tick, 1);
    step(3);
    check("t2_q1",    bus.q,    1);
    check("t2_tick1", bus.tick, 1);
    step(3);
    check("t2_q0",    bus.q,    0);
    check("t2_done",  bus.done, 1);
    check("t2_busy0", bus.busy, 0);
    step(1);
    check("t2_done_pulse", bus.done, 0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t2_hold_q",    bus.q,    0);
      check("t2_hold_busy", bus.busy, 0);
    end

    // Auto-reload: 2,1,2,1 ... never 0
    bus.auto_reload = 1'b1;
    bus.div_max     = 0;
    load_pulse(8'd2);
    start_pulse();
    check("t3_q_start", bus.q, 2);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t3_q",    bus.q,    (i % 2 == 0) ? 1 : 2);
      check("t3_done", bus.done, (i % 2 == 1) ? 1 : 0);
      check("t3_busy", bus.busy, 1);
    end
    bus.auto_reload = 1'b0;

    // Pause and div_max change
    load_pulse(8'h20);
    bus.div_max = 9;
    start_pulse();
    step(5);
    bus.enable = 1'b0;
    step(7);
    check("t4_pause_q",    bus.q,    8'h20);
    check("t4_pause_tick", bus.tick, 0);
    check("t4_pause_busy", bus.busy, 1);
    bus.enable  = 1'b1;
    bus.div_max = 1;
    step(1);
    check("t4_fast_q",    bus.q,    8'h1F);
    check("t4_fast_tick", bus.tick, 1);
    step(1);
    check("t4_gap_tick", bus.tick, 0);
    step(1);
    check("t4_q2",    bus.q,    8'h1E);
    check("t4_tick2", bus.tick, 1);

    // Edge/priority cases
    load_pulse(8'd0);
    start_pulse();
    check("t5_zero_done", bus.done, 1);
    check("t5_zero_busy", bus.busy, 0);
    step(1);
    check("t5_zero_pulse", bus.done, 0);
    start_pulse();
    check("t5_redone", bus.done, 1);
    check("t5_rebusy", bus.busy, 0);
    bus.load_value = 8'd4;
    bus.load       = 1'b1;
    bus.start      = 1'b1;
    step(1);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    check("t5_loadwin_q",    bus.q,    4);
    check("t5_loadwin_busy", bus.busy, 0);
    check("t5_loadwin_done", bus.done, 0);
    step(1);
    check("t5_idle_hold", bus.busy, 0);
    bus.div_max = 3;
    start_pulse();
    check("t5_run", bus.busy, 1);
    step(2);
    start_pulse();
    check("t5_ign_q",    bus.q,    4);
    check("t5_ign_tick", bus.tick, 0);
    step(1);
    check("t5_ign_tick_q", bus.q,    3);
    check("t5_ign_tick_t", bus.tick, 1);

    // Restart from DONE with nibble borrow
    bus.div_max = 0;
    load_pulse(8'h10);
    start_pulse();
    wait_done("t6_first_done", 40);
    check("t6_first_q", bus.q, 0);
    step(1);
    start_pulse();
    check("t6_restart_q",    bus.q,    8'h10);
    check("t6_restart_busy", bus.busy, 1);
    step(1);
    check("t6_borrow_q", bus.q,    8'h0F);
    check("t6_borrow_t", bus.tick, 1);
    wait_done("t6_second_done", 40);
    check("t6_second_q", bus.q, 0);
    step(2);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, prescaled WIDTH-bit down-counter with a start/done handshake and optional auto-reload.
- Counterpart to the team's up-counter: counts down from a loaded value and signals terminal count.
- Sits between board switches/keys (load value, start, enable) and the hex display path; q[7:4] and q[3:0] feed the existing seven-segment decoders.
- Prescaler turns the fast clock into a visible count rate.

Parameters:
WIDTH, 8, count width
DIV_WIDTH, 26, prescaler counter width (sized for a 50 MHz board clock)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
load  input  1  synchronous load strobe; q and reload register take load_value
load_value  input  WIDTH  value captured on load
start  input  1  begin countdown (IDLE/DONE only)
enable  input  1  1 = count advances in RUN; 0 = freeze q and prescaler
auto_reload  input  1  1 = reload and keep running at terminal count
div_max  input  DIV_WIDTH  tick period minus one (0 = tick every enabled cycle)
q  output  WIDTH  current count
tick  output  1  one-cycle pulse on every decrement
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at terminal count

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- reset=0, at any time: state IDLE, q=0, reload_reg=0, prescaler=0, tick=0, done=0, busy=0.
- Reset released mid-count: restarts from IDLE with q=0.
- Priority: load > start > counting.
- load=1, any state:
  - q<=load_value, reload_reg<=load_value, prescaler<=0, state<=IDLE.
  - Also clears any pending start. tick=0, done=0 that cycle.
- start=1 in IDLE or DONE (load=0):
  - IDLE: if q!=0, go to RUN with prescaler<=0; if q==0, go to DONE and pulse done.
  - DONE: q<=reload_reg. If reload_reg!=0 go to RUN; else stay in DONE and pulse done again.
- start in RUN is ignored.
- RUN, enable=0: q, prescaler and state hold; tick=0.
- RUN, enable=1:
  - Tick condition: prescaler>=div_max. The >= is required so that lowering div_max mid-count does not wrap.
  - Not a tick: prescaler<=prescaler+1.
  - Tick: prescaler<=0, tick=1 in the cycle q shows the new value, q<=q-1.
  - Terminal tick (q==1, so q would become 0):
    - auto_reload=0: q<=0, state<=DONE, done=1 for one cycle, coincident with q==0.
    - auto_reload=1: q<=reload_reg and stay in RUN. done=1 and tick=1 for one cycle; q never displays 0.
  - auto_reload is sampled only at the terminal tick.
- Decrement period is div_max+1 enabled cycles. The first decrement comes div_max+1 cycles after the cycle in which start is accepted.
- busy=1 exactly while state==RUN (registered; rises the cycle after start is accepted).
- DONE: q holds 0 and busy=0 until load or start.
- No underflow: q never decrements past 0 in any mode.
- div_max=0: q decrements every enabled cycle.

Test Plan:
- Reset/load basics: reset low mid-run with q=0x37 -> next sample q=0, busy=0, tick=0, done=0. Release, load_value=0x05, load pulse -> q=0x05, state IDLE, busy=0.
- Basic countdown: load 3, div_max=2, enable=1, start pulse -> busy rises next cycle; q goes 2,1,0 at 3-cycle spacing with tick pulses. done=1 for one cycle with q=0, then busy=0, q stays 0 for 10 cycles.
- Auto-reload: load 2, div_max=0, auto_reload=1, start -> q sequence 1,2,1,2…; done pulses every 2nd tick; q never 0; busy stays 1.
- Pause and div_max change: mid-run enable=0 for 7 cycles -> q and prescaler frozen, no tick. Set div_max from 9 to 1 while prescaler=5 -> tick on next enabled cycle, then every 2 cycles.
- Edge/priority: load 0 then start -> DONE, one done pulse, busy never rises. Assert load and start together in DONE with load_value=4 -> q=4, state IDLE (load wins). start during RUN -> no effect on q or prescaler.
- Restart from DONE: after terminal count with reload_reg=0x10, start -> q=0x10, RUN. Count from 0x10 down to 0, confirming the borrow across the nibble boundary, 0x10 -> 0x0F.
